// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit processor core.
// Holds the opcode constants, the sequencer state encoding and reset values.
package cpu_pkg;

    localparam int unsigned XLEN = 16;
    localparam int unsigned OPW  = 4;
    localparam int unsigned CCW  = 3;

    localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 16'h3000;
    localparam logic [CCW-1:0]  CC_RESET         = 3'b010;

    localparam logic [OPW-1:0] OP_BR   = 4'b0000;
    localparam logic [OPW-1:0] OP_ADD  = 4'b0001;
    localparam logic [OPW-1:0] OP_AND  = 4'b0101;
    localparam logic [OPW-1:0] OP_NOT  = 4'b1001;
    localparam logic [OPW-1:0] OP_JMP  = 4'b1100;
    localparam logic [OPW-1:0] OP_LEA  = 4'b1110;
    localparam logic [OPW-1:0] OP_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/cc_unit.sv
// cc_unit: N/Z/P condition-code register and branch-taken evaluation.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cc_we                 load cc from alu_result this cycle
//   alu_result            value being written back
//   dec_n, dec_z, dec_p   branch condition mask
//   is_br, is_jmp         conditional branch / unconditional jump in EXEC
//   cc                    condition codes {N,Z,P}
//   taken_c               combinational branch-taken indication
module cc_unit
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cc_we,
    input  logic [XLEN-1:0] alu_result,
    input  logic            dec_n,
    input  logic            dec_z,
    input  logic            dec_p,
    input  logic            is_br,
    input  logic            is_jmp,
    output logic [CCW-1:0]  cc,
    output logic            taken_c
);

    logic is_zero;
    assign is_zero = (alu_result == '0);

    // CC register; loaded only by writing instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= CC_RESET;
        end else if (cc_we) begin
            cc <= {alu_result[XLEN-1], is_zero, ~alu_result[XLEN-1] & ~is_zero};
        end
    end

    // Evaluated against the cc held before this cycle; a zero mask never takes
    always_comb begin
        taken_c = is_jmp | (is_br & ((dec_n & cc[2]) | (dec_z & cc[1]) | (dec_p & cc[0])));
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute control for the 16-bit core.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   run                      start/continue execution (sampled in IDLE and end of EXEC)
//   mem_req, mem_addr        instruction fetch request / address (= pc)
//   mem_ack, mem_rdata       fetch acknowledge with same-cycle data
//   ir                       instruction register feeding the decoder
//   dec_we_reg, dec_branch   decoder write / branch indications
//   dec_n, dec_z, dec_p      decoder branch-condition mask
//   alu_result, target_addr  writeback value / branch target from the datapath
//   pc, rf_we, cc, halted    program counter, write strobe, condition codes, halt flag
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] ir,
    input  logic            dec_we_reg,
    input  logic            dec_branch,
    input  logic            dec_n,
    input  logic            dec_z,
    input  logic            dec_p,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] target_addr,
    output logic [XLEN-1:0] pc,
    output logic            rf_we,
    output logic [CCW-1:0]  cc,
    output logic            halted
);

    seq_state_e state_q;
    seq_state_e state_d;

    logic [OPW-1:0] opcode;
    logic           in_exec;
    logic           fetch_done;
    logic           cc_we;
    logic           is_br;
    logic           is_jmp;
    logic           taken;

    assign opcode     = ir[XLEN-1:XLEN-OPW];
    assign in_exec    = (state_q == ST_EXEC);
    // mem_req is high only in FETCH, so an ack outside a fetch is ignored
    assign fetch_done = mem_req & mem_ack;
    assign cc_we      = in_exec & dec_we_reg;
    assign is_br      = in_exec & dec_branch & (opcode == OP_BR);
    assign is_jmp     = in_exec & dec_branch & (opcode == OP_JMP);
    assign mem_addr   = pc;
    // Write strobe follows the decoder during the single EXEC cycle
    assign rf_we      = cc_we;

    cc_unit u_cc_unit (
        .clk        (clk),
        .rst_n      (rst_n),
        .cc_we      (cc_we),
        .alu_result (alu_result),
        .dec_n      (dec_n),
        .dec_z      (dec_z),
        .dec_p      (dec_p),
        .is_br      (is_br),
        .is_jmp     (is_jmp),
        .cc         (cc),
        .taken_c    (taken)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH:  if (fetch_done) state_d = ST_DECODE;
            ST_DECODE: state_d = (opcode == OP_TRAP) ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_d = run ? ST_FETCH : ST_IDLE;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Registered state-derived outputs, aligned with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req <= 1'b0;
            halted  <= 1'b0;
        end else begin
            mem_req <= (state_d == ST_FETCH);
            halted  <= (state_d == ST_HALT);
        end
    end

    // PC and IR; a taken branch in EXEC replaces the increment done in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RESET;
            ir <= '0;
        end else if (fetch_done) begin
            pc <= pc + XLEN'(1);
            ir <= mem_rdata;
        end else if (in_exec && taken) begin
            pc <= target_addr;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer.
// A reference model of pc/cc/ir pushes the expected result of each instruction
// when it is fetched; the entry is popped and compared once the instruction retires.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        dec_we_reg;
    logic        dec_branch;
    logic        dec_n;
    logic        dec_z;
    logic        dec_p;
    logic [15:0] alu_result;
    logic [15:0] target_addr;
    logic [15:0] pc;
    logic        rf_we;
    logic [2:0]  cc;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_pc;
    logic [2:0]  m_cc;
    logic [15:0] m_ir;

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  cc;
        logic [15:0] ir;
        logic        we;
    } exp_t;

    exp_t sb_q[$];

    cpu_sequencer #(.PC_RESET(16'h3000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .dec_we_reg  (dec_we_reg),
        .dec_branch  (dec_branch),
        .dec_n       (dec_n),
        .dec_z       (dec_z),
        .dec_p       (dec_p),
        .alu_result  (alu_result),
        .target_addr (target_addr),
        .pc          (pc),
        .rf_we       (rf_we),
        .cc          (cc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Fetch, decode and execute one instruction; mask is {n,z,p}
    task automatic do_instr(input logic [15:0] instr, input int delay, input logic we,
                            input logic br, input logic [2:0] mask, input logic [15:0] alu,
                            input logic [15:0] tgt, input logic run_next);
        exp_t        e;
        int          k;
        logic [15:0] ir_before;
        logic [15:0] dec_pc;
        logic        trap;
        logic        taken;
        k = 0;
        while (mem_req !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_wait: mem_req=%b after %0d cycles, required 1", mem_req, k);
            return;
        end
        checks++;
        if (mem_addr !== m_pc) begin
            errors++;
            $display("FAIL fetch_addr: mem_addr=%h required %h", mem_addr, m_pc);
        end
        ir_before = m_ir;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== m_pc || ir !== ir_before) begin
                errors++;
                $display("FAIL fetch_hold[%0d]: req=%b addr=%h ir=%h required 1 %h %h",
                         i, mem_req, mem_addr, ir, m_pc, ir_before);
            end
        end
        mem_ack     = 1'b1;
        mem_rdata   = instr;
        dec_we_reg  = we;
        dec_branch  = br;
        {dec_n, dec_z, dec_p} = mask;
        alu_result  = alu;
        target_addr = tgt;

        trap   = (instr[15:12] == 4'hF);
        m_ir   = instr;
        m_pc   = m_pc + 16'd1;
        dec_pc = m_pc;
        taken  = br && ((instr[15:12] == 4'hC) || (instr[15:12] == 4'h0 && (mask & m_cc) != 3'b000));
        if (!trap) begin
            if (we) m_cc = {alu[15], alu == 16'h0000, !alu[15] && alu != 16'h0000};
            if (taken) m_pc = tgt;
        end
        e.pc = m_pc;
        e.cc = m_cc;
        e.ir = instr;
        e.we = we & ~trap;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        run = run_next;
        e = sb_q.pop_front();
        checks++;
        if (ir !== e.ir) begin
            errors++;
            $display("FAIL decode_ir: ir=%h required %h", ir, e.ir);
        end
        checks++;
        if (pc !== dec_pc || rf_we !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL decode_state: pc=%h rf_we=%b req=%b required %h 0 0", pc, rf_we, mem_req, dec_pc);
        end
        if (trap) begin
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL halt_enter: halted=%b req=%b required 1 0", halted, mem_req);
            end
            return;
        end
        @(negedge clk);
        checks++;
        if (rf_we !== e.we) begin
            errors++;
            $display("FAIL exec_rf_we: rf_we=%b required %b", rf_we, e.we);
        end
        @(negedge clk);
        checks++;
        if (pc !== e.pc) begin
            errors++;
            $display("FAIL retire_pc: pc=%h required %h", pc, e.pc);
        end
        checks++;
        if (cc !== e.cc) begin
            errors++;
            $display("FAIL retire_cc: cc=%b required %b", cc, e.cc);
        end
        checks++;
        if (rf_we !== 1'b0 || mem_req !== run_next) begin
            errors++;
            $display("FAIL retire_next: rf_we=%b req=%b required 0 %b", rf_we, mem_req, run_next);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        dec_we_reg = 1'b0;
        dec_branch = 1'b0;
        {dec_n, dec_z, dec_p} = 3'b000;
        alu_result = 16'h0000;
        target_addr = 16'h0000;
        m_pc = 16'h3000;
        m_cc = 3'b010;
        m_ir = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 16'h3000 || ir !== 16'h0000 || cc !== 3'b010) begin
            errors++;
            $display("FAIL reset_regs: pc=%h ir=%h cc=%b required 3000 0000 010", pc, ir, cc);
        end
        checks++;
        if (mem_req !== 1'b0 || rf_we !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: req=%b rf_we=%b halted=%b required 0 0 0", mem_req, rf_we, halted);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_run: req=%b required 0", mem_req);
        end
        run = 1'b1;
    endtask

    task automatic test_add();
        do_instr(16'h1021, 0, 1'b1, 1'b0, 3'b000, 16'h0005, 16'h0000, 1'b1);
    endtask

    task automatic test_branch();
        do_instr(16'h1021, 0, 1'b1, 1'b0, 3'b000, 16'h8000, 16'h0000, 1'b1);
        do_instr(16'h0805, 0, 1'b0, 1'b1, 3'b100, 16'h0000, 16'h4000, 1'b1);
        do_instr(16'h0405, 0, 1'b0, 1'b1, 3'b010, 16'h0000, 16'h5000, 1'b1);
    endtask

    task automatic test_jmp();
        do_instr(16'hC1C0, 0, 1'b0, 1'b1, 3'b000, 16'h0000, 16'h1234, 1'b1);
    endtask

    task automatic test_ack_delay();
        do_instr(16'h5020, 4, 1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000, 1'b1);
    endtask

    task automatic test_run_drop();
        // zero-mask BR never taken; run dropped mid-instruction lets it retire
        do_instr(16'h0005, 1, 1'b0, 1'b1, 3'b000, 16'h0000, 16'h7777, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || pc !== m_pc) begin
                errors++;
                $display("FAIL idle_hold: req=%b pc=%h required 0 %h", mem_req, pc, m_pc);
            end
        end
        run = 1'b1;
    endtask

    task automatic test_wrap();
        do_instr(16'hC1C0, 0, 1'b0, 1'b1, 3'b000, 16'h0000, 16'hFFFF, 1'b1);
        do_instr(16'h1021, 2, 1'b1, 1'b0, 3'b000, 16'h0001, 16'h0000, 1'b1);
    endtask

    task automatic test_halt();
        do_instr(16'hF025, 0, 1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000, 1'b1);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL halt_stay: halted=%b req=%b required 1 0", halted, mem_req);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int k;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 16'h3000;
        m_cc = 3'b010;
        m_ir = 16'h0000;
        run = 1'b1;
        k = 0;
        while (mem_req !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h3000) begin
            errors++;
            $display("FAIL refetch: req=%b addr=%h required 1 3000", mem_req, mem_addr);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_req: req=%b halted=%b required 0 0", mem_req, halted);
        end
        checks++;
        if (pc !== 16'h3000 || cc !== 3'b010 || ir !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_regs: pc=%h cc=%b ir=%h required 3000 010 0000", pc, cc, ir);
        end
        // late ack arrives while and after reset is released with run low
        mem_ack = 1'b1;
        mem_rdata = 16'h1021;
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || ir !== 16'h0000 || pc !== 16'h3000) begin
                errors++;
                $display("FAIL late_ack: req=%b ir=%h pc=%h required 0 0000 3000", mem_req, ir, pc);
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_jmp();
        test_ack_delay();
        test_run_drop();
        test_wrap();
        test_halt();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit processor core. Fetches each instruction from memory over a request/acknowledge handshake and holds it in the instruction register that drives the instruction decoder. Owns the program counter and the N/Z/P condition-code register. Turns the decoder's combinational write/branch outputs into single-cycle register-file write strobes and PC updates.

## Interface
Parameters:
- PC_RESET, 16'h3000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- run  in  1  level; start/continue execution from IDLE.
- mem_req  out  1  instruction-fetch request.
- mem_addr  out  16  fetch address; equals pc.
- mem_ack  in  1  fetch acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  16  fetched instruction word.
- ir  out  16  instruction register, feeds the decoder.
- dec_we_reg  in  1  decoder register-write indication.
- dec_branch  in  1  decoder branch/jump indication.
- dec_n, dec_z, dec_p  in  1 each  decoder branch-condition mask bits.
- alu_result  in  16  value being written back; source for the CC update.
- target_addr  in  16  branch/jump target from the datapath.
- pc  out  16  program counter.
- rf_we  out  1  register-file write strobe, one cycle per writing instruction.
- cc  out  3  condition codes {N,Z,P}.
- halted  out  1  high in HALT.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE: no outputs active. Goes to FETCH when run=1.
- FETCH: mem_req=1 and mem_addr=pc, held stable until mem_ack.
  - On mem_ack: ir<=mem_rdata, pc<=pc+1 (16-bit wrap, 16'hFFFF→16'h0000), go to DECODE.
  - mem_ack while mem_req=0 is ignored.
- DECODE: one settle cycle for the decoder.
  - If ir[15:12]==4'b1111 (TRAP/halt), go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - rf_we=dec_we_reg.
  - If dec_we_reg: cc<={alu_result[15], alu_result==0, ~alu_result[15] & (alu_result!=0)}.
  - If dec_branch and ir[15:12]==4'b1100 (JMP): always taken.
  - If dec_branch and ir[15:12]==4'b0000 (BR): taken when (dec_n&cc[2])|(dec_z&cc[1])|(dec_p&cc[0]). BR with a zero mask is never taken.
  - When a branch is taken: pc<=target_addr. This overrides the increment done in FETCH.
  - Next state is FETCH if run=1, otherwise IDLE.
- Branch evaluation uses the cc value held before this EXEC cycle. Writing instructions never branch, so an update and an evaluation never conflict.
- HALT: halted=1. Exits only through reset.
- Reset, including mid-fetch: state=IDLE, pc=PC_RESET, ir=16'h0000, cc=3'b010, mem_req=0, rf_we=0, halted=0, all applied immediately (asynchronous). A pending fetch is abandoned and a late mem_ack is ignored.

## Timing
- Minimum 3 cycles per instruction (FETCH with same-cycle ack, DECODE, EXEC). Each cycle of mem_ack delay adds one cycle.
- rf_we is exactly one cycle wide, in EXEC only.
- pc and ir are registered outputs.
- The new pc is visible the cycle after EXEC, which is the next FETCH address.
- run is sampled only in IDLE and at the end of EXEC. Dropping run during FETCH/DECODE completes the current instruction.

## Structure
- Shared package cpu_pkg:
  - opcode constants (BR=4'b0000, ADD=4'b0001, AND=4'b0101, NOT=4'b1001, JMP=4'b1100, LEA=4'b1110, TRAP=4'b1111);
  - the sequencer state enum;
  - the default PC_RESET.
- One sub-module, cc_unit: the CC register, its update logic and the branch-taken evaluation (inputs cc_we, alu_result, dec_n/z/p, is_br, is_jmp).

## Test plan
- Reset and run=1 with ack delay 0, mem_rdata=16'h1021 (ADD), alu_result=16'h0005 → mem_addr=16'h3000; rf_we pulses once in the 3rd cycle; cc=3'b001; pc=16'h3001.
- alu_result=16'h8000 on a write, then BR with n=1 (16'h0805) and target_addr=16'h4000 → pc=16'h4000. Same with BRz (16'h0405) → pc=previous pc+1.
- JMP (16'hC1C0) with target_addr=16'h1234 → pc=16'h1234; rf_we stays 0.
- mem_ack delayed 4 cycles → mem_req and mem_addr held stable for 5 cycles; ir is unchanged until the ack.
- pc=16'hFFFF with a non-branch fetch → pc wraps to 16'h0000.
- Fetch 16'hF025 → halted=1 and no further mem_req. Assert rst_n=0 mid-FETCH of a later run → mem_req drops immediately; pc=16'h3000, cc=3'b010.
